// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pkg
//  Purpose  : Shared types and helpers for the serial framing datapath.
//             Provides the framer state encoding and the frame-length helper.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Framer state: IDLE = nothing on the line, DATA = data bits on x,
    // PAR = the even-parity bit on x.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_e;

    // Number of x_valid cycles one frame occupies.
    function automatic int frame_len(input int width, input int parity_en);
        return width + ((parity_en != 0) ? 1 : 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : piso_shifter
//  Purpose  : Parallel-in / serial-out shift register. Holds the word being
//             serialized; sout is always the bit at the head of the register.
//  Ports    : clk, rst_n  - clock, asynchronous active-low reset
//             load        - capture d (has priority over shift)
//             shift       - advance the register by one bit, filling with 0
//             d [WIDTH]   - parallel load value
//             sout        - head bit (bit 0 if LSB-first, bit WIDTH-1 if not)
//  Revision : 1.0 - initial release
// ============================================================================
module piso_shifter
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             sout
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] sr_shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sr_shifted = {sr_q[WIDTH-2:0], 1'b0};
            assign sout       = sr_q[WIDTH-1];
        end else begin : g_lsb_first
            assign sr_shifted = {1'b0, sr_q[WIDTH-1:1]};
            assign sout       = sr_q[0];
        end
    endgenerate

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift) begin
            sr_d = sr_shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_word_framer.sv
`default_nettype none
// ============================================================================
//  Module   : serial_word_framer
//  Purpose  : Accepts a parallel word over valid/ready and sends it out one
//             bit per clock on x, optionally followed by an even-parity bit.
//             Back-to-back words are accepted in the frame_end cycle so
//             consecutive frames leave no gap on the line.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             din, din_valid      - word to send and its qualifier
//             din_ready           - word can be accepted this cycle
//             x, x_valid          - registered serial bit and its qualifier
//             frame_start         - first bit of a frame
//             frame_end           - last bit of a frame (parity if enabled)
//             busy                - a frame is on the line (equals x_valid)
//  Revision : 1.0 - initial release
// ============================================================================
module serial_word_framer
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int                   c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0]   c_last_bit = c_cnt_w'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q,   cnt_d;
    logic                 par_q,   par_d;
    logic                 x_q,     x_d;
    logic                 fs_q,    fs_d;

    logic                 accept;
    logic                 last_data;
    logic                 sh_load;
    logic                 sh_shift;
    logic                 sh_out;
    logic                 first_bit;
    logic [WIDTH-1:0]     load_word;

    // The first bit goes straight into x_q at the accept edge, so the
    // shifter is loaded with the word already advanced by one position;
    // its head then always holds the bit that x_q takes next.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign first_bit = din[WIDTH-1];
            assign load_word = {din[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign first_bit = din[0];
            assign load_word = {1'b0, din[WIDTH-1:1]};
        end
    endgenerate

    piso_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sh_load),
        .shift (sh_shift),
        .d     (load_word),
        .sout  (sh_out)
    );

    assign last_data   = (state_q == DATA) && (cnt_q == c_last_bit);
    assign frame_end   = PARITY_EN ? (state_q == PAR) : last_data;
    assign din_ready   = (state_q == IDLE) || frame_end;
    assign accept      = din_valid && din_ready;

    assign x           = x_q;
    assign x_valid     = (state_q != IDLE);
    assign busy        = x_valid;
    assign frame_start = fs_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        x_d      = 1'b0;
        fs_d     = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            DATA: begin
                if (cnt_q != c_last_bit) begin
                    cnt_d    = cnt_q + 1'b1;
                    x_d      = sh_out;
                    sh_shift = 1'b1;
                end else if (PARITY_EN) begin
                    state_d = PAR;
                    x_d     = par_q;
                end else begin
                    state_d = IDLE;
                end
            end
            PAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept is only possible in IDLE or in the frame_end cycle, so it
        // cleanly overrides whatever the frame in flight would do next.
        if (accept) begin
            state_d = DATA;
            cnt_d   = '0;
            par_d   = ^din;
            x_d     = first_bit;
            fs_d    = 1'b1;
            sh_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            x_q     <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            x_q     <= x_d;
            fs_q    <= fs_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_word_framer.md
# serial_word_framer

Parallel-to-serial framer that sits directly upstream of the serial parity detector. It accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock on a serial line `x`, optionally followed by an even-parity bit. When parity is enabled, the downstream detector's running-odd-parity output returns to 0 at the end of every well-formed frame.

## Interface
- `WIDTH`, 8: data word width in bits; legal range 2..32.
- `MSB_FIRST`, 0: 0 = bit 0 is sent first; 1 = bit WIDTH-1 is sent first.
- `PARITY_EN`, 1: 1 = append one even-parity bit after the data; 0 = data bits only.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `din`  in  WIDTH: word to serialize; sampled only on handshake.
- `din_valid`  in  1: `din` is valid.
- `din_ready`  out  1: framer can accept a word this cycle.
- `x`  out  1: serial data (registered); feeds the detector's `x`.
- `x_valid`  out  1: `x` carries a frame bit this cycle.
- `frame_start`  out  1: high for the first bit of a frame.
- `frame_end`  out  1: high for the last bit of a frame (the parity bit if enabled).
- `busy`  out  1: a frame is in progress.

## Operation
- Frame length: L = WIDTH + PARITY_EN bits.
- States:
  - IDLE: no frame in progress.
  - DATA: shifting data bits.
  - PAR: emitting the parity bit; this state is unreachable when PARITY_EN=0.
- Handshake:
  - A word is accepted on a rising edge where `din_valid && din_ready`.
  - `din` is captured into the shift register.
  - The parity register is loaded with ^din.
  - The bit counter is cleared.
- `din_ready` is combinational:
  - High in IDLE.
  - High in the cycle where `frame_end` is high (back-to-back acceptance).
  - Low otherwise.
  - `din_valid` is ignored whenever `din_ready` is low.
- State transitions:
  - IDLE → DATA on accept.
  - DATA → DATA while bit count < WIDTH-1.
  - After the last data bit: → PAR if PARITY_EN, else → DATA (if a new word is accepted in that same cycle) or → IDLE.
  - PAR → DATA on a simultaneous accept, else → IDLE.
- Parity bit value = XOR of all WIDTH data bits, so the count of ones over data + parity is even.
- Bit counter width is $clog2(WIDTH); it never wraps mid-frame and is cleared on every accept.
- Asynchronous reset takes effect immediately, including mid-frame. The partial frame is abandoned; no `frame_end` is issued for it.

## Timing
- Reset values:
  - `x`=0, `x_valid`=0, `frame_start`=0, `frame_end`=0, `busy`=0.
  - State is IDLE, so `din_ready`=1.
- Latency: word accepted at edge k → first bit on `x` with `x_valid`=1 and `frame_start`=1 during cycle k+1 (after edge k).
- A frame occupies exactly L consecutive cycles with `x_valid`=1.
- `frame_end` is high in the L-th cycle of the frame only.
- `busy` equals `x_valid`.
- Back-to-back: with a new accept in the `frame_end` cycle, the next frame's `frame_start` is in the very next cycle, leaving no gap.
- Between frames, `x` holds 0 and `x_valid`=0.

## Structure
- Shared package `serial_pkg`:
  - State enum: `IDLE`, `DATA`, `PAR`.
  - Function `frame_len(WIDTH, PARITY_EN)`.
- One sub-module, `piso_shifter`:
  - Parameters: WIDTH, MSB_FIRST.
  - Ports: load, shift, d, serial out.
  - Holds the shift register only.
- The FSM, counter and parity register live in the top.

## Test plan
- Reset and single frame (WIDTH=8, LSB-first, PARITY_EN=1):
  - Release reset, then accept 8'hA5.
  - `x` = 1,0,1,0,0,1,0,1, then parity 0.
  - `frame_start` on bit 1, `frame_end` on bit 9.
  - Detector `z` = 0 after the frame.
- Odd-weight word: accept 8'h07 → `x` = 1,1,1,0,0,0,0,0, then parity 1, for 9 cycles.
- Back-to-back:
  - `din_valid` held high with 8'hA5 then 8'h07.
  - Second accept occurs in the `frame_end` cycle.
  - 18 contiguous `x_valid` cycles.
  - `frame_start` at cycles 1 and 10.
- Stall: `din_valid` pulsed high with 8'hFF in frame cycle 4 → ignored; only the original word is sent; `din_ready`=0 throughout cycles 1-8.
- Reset mid-frame:
  - Assert `rst_n`=0 at frame cycle 5.
  - All outputs go to their reset values immediately; no `frame_end`.
  - The next accept starts a clean frame.
- MSB_FIRST=1, PARITY_EN=0: accept 8'hA5 → `x` = 1,0,1,0,0,1,0,1 over 8 cycles, with `frame_end` on cycle 8.
